xpt_frame_arbiter: RTL

- Frame-locked round-robin arbiter/scheduler for one output port of the 16x16 crosspoint router. One instance per output port.
- Takes per-input-port requests and per-input-port frame_n. Issues a one-hot grant that steers the output-port mux.
- Holds the grant for a whole frame, then releases it. Reclaims the port if a granted requester never starts its frame.

---
 rtl/xpt_frame_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/xpt_frame_arbiter.sv
// -----------------------------------------------------------------------------
// xpt_frame_arbiter
//
// Frame-locked round-robin arbiter for one output port of the 16x16
// crosspoint router. One instance sits on each output port. A one-hot,
// registered grant steers that port's output mux. The grant is held for a
// whole frame and then released. If a granted requester never starts its
// frame, the port is reclaimed.
//
// Ports:
//   clock        in   system clock; all state changes on its rising edge
//   reset_n      in   asynchronous active-low reset
//   request[N]   in   level request per input port, held until served
//   frame_n[N]   in   per-input frame_n, active-low; high on the last bit
//   grant[N]     out  one-hot registered grant, zero when there is no owner
//   busy_n       out  active-low, low whenever the arbiter is not idle
//   owner[IW]    out  index of the current or last granted port
//   timeout_err  out  one-cycle pulse when a silent owner is forced off
//
// Handshake: request is a level, not a pulse. A port raises request[i] and
// keeps it high until it is granted. Once granted, the port starts its frame
// by driving frame_n[i] low. It keeps frame_n[i] low for the frame and drives
// it high for the cycle that carries the last bit; grant is still high in
// that cycle. Dropping request[i] before the frame starts abandons the grant.
// After the frame starts, request and the frame_n bits of other ports are
// ignored until the release.
// -----------------------------------------------------------------------------
module xpt_frame_arbiter #(
    parameter int N       = 16,
    parameter int TIMEOUT = 64,
    localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [N-1:0]  request,
    input  logic [N-1:0]  frame_n,
    output logic [N-1:0]  grant,
    output logic          busy_n,
    output logic [IW-1:0] owner,
    output logic          timeout_err
);

    // The wait counter counts 0..TIMEOUT-1. It is cleared on every grant and
    // stops at the terminal count, so it can never wrap.
    localparam int            CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GNT_WAIT = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    state_e          state_q,       state_d;
    logic [N-1:0]    grant_q,       grant_d;
    logic [IW-1:0]   owner_q,       owner_d;
    logic [IW-1:0]   rr_ptr_q,      rr_ptr_d;
    logic [CW-1:0]   wait_cnt_q,    wait_cnt_d;
    logic            timeout_err_q, timeout_err_d;

    // Round-robin search result: the first set request bit at or above
    // rr_ptr, wrapping from N-1 back to 0.
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW:0]     cand_sum;
    logic [IW-1:0]   cand_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand_idx  = '0;
        for (int k = 0; k < N; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (cand_sum >= (IW+1)'(N)) begin
                cand_sum = cand_sum - (IW+1)'(N);
            end
            cand_idx = cand_sum[IW-1:0];
            if (!win_found && request[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d          = ST_GNT_WAIT;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    owner_d          = win_idx;
                    // Move the pointer past the winner so that the winner
                    // loses to any other pending port next time.
                    rr_ptr_d         = (win_idx == LAST_IDX) ? '0 : win_idx + IW'(1);
                    wait_cnt_d       = '0;
                end
            end

            ST_GNT_WAIT: begin
                if (!frame_n[owner_q]) begin
                    state_d = ST_ACTIVE;
                end else if (!request[owner_q]) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d       = ST_RELEASE;
                    grant_d       = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end

            ST_ACTIVE: begin
                // frame_n high marks the last-bit cycle. The grant stays up
                // through that cycle and drops at the following edge.
                if (frame_n[owner_q]) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                end
            end

            ST_RELEASE: begin
                // One dead cycle with no grant, so the output mux never
                // switches directly from one source to the next.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // busy_n is decoded from the state register. An asynchronous reset
    // therefore raises it at once, without waiting for a clock edge.
    assign grant       = grant_q;
    assign busy_n      = (state_q == ST_IDLE);
    assign owner       = owner_q;
    assign timeout_err = timeout_err_q;

endmodule
